// File: rtl/audio_sample_buffer_pkg.sv
// Shared types and constants for the audio sample buffer slice.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 32;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    RUN     = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  // Saturating 8-bit increment used by the underrun counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/audio_sample_buffer_if.sv
// Sender-side handshake bundle: request ticks in, samples and stream framing out.
interface audio_sample_buffer_if;
  import audio_pkg::*;

  logic    req_tick;
  logic    req_mode;
  logic    out_valid;
  sample_t out_data;
  logic    snd_start;
  logic    snd_end;
  logic    snd_22k;

  // Buffer side
  modport master (
    input  req_tick, req_mode,
    output out_valid, out_data, snd_start, snd_end, snd_22k
  );

  // I2S sender side
  modport slave (
    output req_tick, req_mode,
    input  out_valid, out_data, snd_start, snd_end, snd_22k
  );
endinterface

// File: rtl/audio_sample_buffer_fifo_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read that holds
// its value between reads so it can drive the sender data bus directly.
module audio_fifo_ram
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  sample_t               wr_data_i,
  input  logic                  rd_en_i,
  input  logic [DEPTH_LOG2-1:0] rd_addr_i,
  output sample_t               rd_data_o
);

  sample_t mem_q [2**DEPTH_LOG2];
  sample_t rd_data_q;

  // Storage array: written on accepted samples only, never reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read register: loads on a pop, otherwise holds the last delivered sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/audio_sample_buffer.sv
// Sample buffer feeding the I2S sender: FIFO pointers/level, stream FSM,
// refill request and underrun/overflow bookkeeping, all in the in_clk domain.
module audio_sample_buffer
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2    = 3,
  parameter int unsigned PREFILL_LEVEL = 2,
  parameter int unsigned LOW_WATER     = 3
) (
  input  logic                  in_clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  sample_t               wr_data,
  output logic                  wr_ready,
  input  logic                  play_start,
  input  logic                  play_stop,
  input  logic                  rate_22k_in,
  audio_sample_buffer_if.master snd,
  output logic                  host_req,
  output logic [DEPTH_LOG2:0]   level,
  output logic [7:0]            underrun_cnt,
  output logic                  overflow
);

  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = LVL_W'(2**DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   PRE_LVL  = LVL_W'(PREFILL_LEVEL);
  localparam logic [DEPTH_LOG2:0]   LOW_LVL  = LVL_W'(LOW_WATER);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = LVL_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  state_e                  state_q;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     level_q, level_d;
  logic                    out_valid_q;
  logic                    snd_start_q;
  logic                    snd_end_q;
  logic                    snd_22k_q;
  logic [7:0]              underrun_q;
  logic                    overflow_q;

  logic                    full;
  logic                    wr_en;
  logic                    tick_ok;
  logic                    pop;
  logic                    start_go;
  sample_t                 rd_data;

  // Handshake qualification; full uses the registered level so a pop in the
  // same cycle cannot free a slot for a write.
  always_comb begin
    full     = (level_q == FULL_LVL);
    wr_en    = wr_valid && !full;
    tick_ok  = snd.req_tick && snd.req_mode && ((state_q == RUN) || (state_q == DRAIN));
    pop      = tick_ok && (level_q != '0);
    start_go = (state_q == IDLE) && play_start && !play_stop;
  end

  // Next-state pointers and fill level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // FIFO bookkeeping registers.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Stream FSM with registered framing pulses, rate latch and status counters.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      snd_start_q <= 1'b0;
      snd_end_q   <= 1'b0;
      snd_22k_q   <= 1'b0;
      underrun_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= pop;
      snd_start_q <= 1'b0;
      snd_end_q   <= 1'b0;
      // Overflow clear on a new stream, then any refused write re-arms it.
      overflow_q  <= (start_go ? 1'b0 : overflow_q) | (wr_valid && full);
      if (start_go)
        underrun_q <= '0;
      else if (tick_ok && (level_q == '0))
        underrun_q <= sat_inc8(underrun_q);

      case (state_q)
        IDLE: begin
          if (start_go) begin
            state_q   <= PREFILL;
            snd_22k_q <= rate_22k_in;
          end
        end
        PREFILL: begin
          if (play_stop) begin
            state_q <= IDLE;
          end else if (level_q >= PRE_LVL) begin
            state_q     <= RUN;
            snd_start_q <= 1'b1;
          end
        end
        RUN: begin
          if (play_stop) state_q <= DRAIN;
        end
        DRAIN: begin
          if (level_q == '0) begin
            state_q   <= IDLE;
            snd_end_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  audio_fifo_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk       (in_clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_en_i   (pop),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  assign wr_ready      = !full;
  assign host_req      = ((state_q == PREFILL) || (state_q == RUN)) && (level_q <= LOW_LVL);
  assign level         = level_q;
  assign underrun_cnt  = underrun_q;
  assign overflow      = overflow_q;
  assign snd.out_valid = out_valid_q;
  assign snd.out_data  = rd_data;
  assign snd.snd_start = snd_start_q;
  assign snd.snd_end   = snd_end_q;
  assign snd.snd_22k   = snd_22k_q;

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Scenario bench for audio_sample_buffer: a sample scoreboard checked by a
// negedge monitor, plus per-scenario inline checks.
module tb_audio_sample_buffer;

  localparam int DEPTH = 8;

  logic        in_clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        play_start;
  logic        play_stop;
  logic        rate_22k_in;
  logic        host_req;
  logic [3:0]  level;
  logic [7:0]  underrun_cnt;
  logic        overflow;

  audio_sample_buffer_if snd_if ();

  audio_sample_buffer #(
    .DEPTH_LOG2    (3),
    .PREFILL_LEVEL (2),
    .LOW_WATER     (3)
  ) dut (
    .in_clk       (in_clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .play_start   (play_start),
    .play_stop    (play_stop),
    .rate_22k_in  (rate_22k_in),
    .snd          (snd_if),
    .host_req     (host_req),
    .level        (level),
    .underrun_cnt (underrun_cnt),
    .overflow     (overflow)
  );

  always #5 in_clk = ~in_clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] sb[$];
  int          mlevel       = 0;
  bit          running      = 1'b0;
  bit          pop_exp      = 1'b0;
  bit          prev_pop_exp = 1'b0;
  int          start_cnt    = 0;
  int          end_cnt      = 0;
  bit          prev_start   = 1'b0;
  bit          prev_end     = 1'b0;

  // Monitor: out_valid must follow an honoured tick by one cycle and carry the
  // scoreboard head; framing pulses are counted and must be one cycle wide.
  always @(negedge in_clk) begin
    logic [31:0] exp_d;
    tests_run++;
    if (snd_if.out_valid !== prev_pop_exp) begin
      tests_failed++;
      $display("FAIL out_valid_timing: got %b want %b at %0t", snd_if.out_valid, prev_pop_exp, $time);
    end
    if (snd_if.out_valid === 1'b1) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL out_data: got %h want <no sample queued> at %0t", snd_if.out_data, $time);
      end else begin
        exp_d = sb.pop_front();
        if (snd_if.out_data !== exp_d) begin
          tests_failed++;
          $display("FAIL out_data: got %h want %h at %0t", snd_if.out_data, exp_d, $time);
        end
      end
    end
    if (snd_if.snd_start === 1'b1) begin
      start_cnt++;
      tests_run++;
      if (prev_start) begin
        tests_failed++;
        $display("FAIL snd_start_width: got 2+ cycles want 1 at %0t", $time);
      end
    end
    if (snd_if.snd_end === 1'b1) begin
      end_cnt++;
      tests_run++;
      if (prev_end) begin
        tests_failed++;
        $display("FAIL snd_end_width: got 2+ cycles want 1 at %0t", $time);
      end
    end
    prev_start   = (snd_if.snd_start === 1'b1);
    prev_end     = (snd_if.snd_end === 1'b1);
    prev_pop_exp = pop_exp;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge in_clk);
      #1;
    end
  endtask

  // One cycle of write/tick stimulus; the scoreboard and model level track what
  // the buffer must accept and deliver.
  task automatic drive(input bit w, input logic [31:0] d, input bit t, input bit m);
    bit acc_w, acc_p;
    acc_w = w && (mlevel < DEPTH);
    acc_p = t && m && running && (mlevel > 0);
    wr_valid       = w;
    wr_data        = d;
    snd_if.req_tick = t;
    snd_if.req_mode = m;
    pop_exp        = acc_p;
    if (acc_w) sb.push_back(d);
    mlevel = mlevel + int'(acc_w) - int'(acc_p);
    @(posedge in_clk);
    #1;
    wr_valid        = 1'b0;
    snd_if.req_tick = 1'b0;
    pop_exp         = 1'b0;
  endtask

  task automatic ctrl(input bit s, input bit p, input bit r);
    play_start  = s;
    play_stop   = p;
    rate_22k_in = r;
    @(posedge in_clk);
    #1;
    play_start = 1'b0;
    play_stop  = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] outs;
    idle(3);
    outs = {snd_if.out_valid, snd_if.snd_start, snd_if.snd_end, snd_if.snd_22k,
            host_req, overflow, wr_ready, level[2:0]};
    tests_run++;
    if (outs !== 10'b0000_0010_00) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want %b", outs, 10'b0000_0010_00);
    end
    tests_run++;
    if ({level, underrun_cnt, snd_if.out_data} !== 44'h0) begin
      tests_failed++;
      $display("FAIL reset_values: got lvl=%0d und=%0d data=%h want 0/0/0", level, underrun_cnt, snd_if.out_data);
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_prefill();
    ctrl(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (host_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL prefill_host_req: got %b want 1", host_req);
    end
    drive(1'b1, 32'hAAAA5555, 1'b0, 1'b0);
    drive(1'b1, 32'h12345678, 1'b0, 1'b0);
    tests_run++;
    if (snd_if.snd_start !== 1'b0 || level !== 4'd2) begin
      tests_failed++;
      $display("FAIL prefill_early: got start=%b lvl=%0d want 0/2", snd_if.snd_start, level);
    end
    idle(1);
    tests_run++;
    if (snd_if.snd_start !== 1'b1) begin
      tests_failed++;
      $display("FAIL snd_start_cycle: got %b want 1", snd_if.snd_start);
    end
    running = 1'b1;
    idle(1);
    tests_run++;
    if (snd_if.snd_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL snd_start_clear: got %b want 0", snd_if.snd_start);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    idle(2);
    tests_run++;
    if (sb.size() != 0 || level !== 4'd0 || start_cnt != 1) begin
      tests_failed++;
      $display("FAIL prefill_delivery: got left=%0d lvl=%0d starts=%0d want 0/0/1", sb.size(), level, start_cnt);
    end
  endtask

  task automatic test_underrun();
    repeat (3) drive(1'b0, 32'h0, 1'b1, 1'b1);
    tests_run++;
    if (underrun_cnt !== 8'd3) begin
      tests_failed++;
      $display("FAIL underrun_3: got %0d want 3", underrun_cnt);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if (underrun_cnt !== 8'd3) begin
      tests_failed++;
      $display("FAIL underrun_mode0: got %0d want 3", underrun_cnt);
    end
    repeat (260) drive(1'b0, 32'h0, 1'b1, 1'b1);
    tests_run++;
    if (underrun_cnt !== 8'd255 || host_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL underrun_sat: got %0d req=%b want 255/1", underrun_cnt, host_req);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) drive(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
    tests_run++;
    if (level !== 4'd8 || wr_ready !== 1'b0 || overflow !== 1'b1 || host_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL full: got lvl=%0d rdy=%b ovf=%b req=%b want 8/0/1/0", level, wr_ready, overflow, host_req);
    end
    drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
    tests_run++;
    if (level !== 4'd7 || wr_ready !== 1'b1 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_pop_write: got lvl=%0d rdy=%b ovf=%b want 7/1/1", level, wr_ready, overflow);
    end
  endtask

  task automatic test_drain();
    int e0;
    repeat (5) drive(1'b0, 32'h0, 1'b1, 1'b1);
    tests_run++;
    if (level !== 4'd2 || host_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_drain: got lvl=%0d req=%b want 2/1", level, host_req);
    end
    e0 = end_cnt;
    ctrl(1'b0, 1'b1, 1'b0);
    tests_run++;
    if (host_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_host_req: got %b want 0", host_req);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    idle(4);
    running = 1'b0;
    tests_run++;
    if (end_cnt != e0 + 1 || level !== 4'd0 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_end: got ends=%0d lvl=%0d left=%0d want %0d/0/0", end_cnt - e0, level, sb.size(), 1);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    idle(2);
    tests_run++;
    if (underrun_cnt !== 8'd255 || host_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_tick: got und=%0d req=%b want 255/0", underrun_cnt, host_req);
    end
  endtask

  task automatic test_wrap_rate();
    int written, e0, cyc;
    bit w, t;
    ctrl(1'b1, 1'b0, 1'b1);
    tests_run++;
    if (snd_if.snd_22k !== 1'b1 || underrun_cnt !== 8'd0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart: got 22k=%b und=%0d ovf=%b want 1/0/0", snd_if.snd_22k, underrun_cnt, overflow);
    end
    drive(1'b1, 32'h5A00_0000, 1'b0, 1'b0);
    drive(1'b1, 32'h5A00_0001, 1'b0, 1'b0);
    idle(1);
    running = 1'b1;
    written = 2;
    cyc = 0;
    while (written < 20 && cyc < 300) begin
      w = ($urandom_range(0, 3) != 0);
      t = ($urandom_range(0, 1) != 0);
      if (w && mlevel < DEPTH) written++;
      drive(w, 32'h5A00_0000 + 32'(written - 1), t, 1'b1);
      tests_run++;
      if (level !== 4'(mlevel) || level > 4'd8) begin
        tests_failed++;
        $display("FAIL wrap_level: got %0d want %0d", level, mlevel);
      end
      cyc++;
    end
    cyc = 0;
    while (mlevel > 0 && cyc < 50) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      cyc++;
    end
    idle(2);
    tests_run++;
    if (written != 20 || sb.size() != 0 || snd_if.snd_22k !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_done: got wr=%0d left=%0d 22k=%b want 20/0/1", written, sb.size(), snd_if.snd_22k);
    end
    e0 = end_cnt;
    ctrl(1'b0, 1'b1, 1'b0);
    idle(3);
    running = 1'b0;
    tests_run++;
    if (end_cnt != e0 + 1 || snd_if.snd_22k !== 1'b1) begin
      tests_failed++;
      $display("FAIL stop_empty: got ends=%0d 22k=%b want 1/1", end_cnt - e0, snd_if.snd_22k);
    end
    ctrl(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (snd_if.snd_22k !== 1'b0 || host_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL rate_relatch: got 22k=%b req=%b want 0/1", snd_if.snd_22k, host_req);
    end
    e0 = end_cnt;
    ctrl(1'b0, 1'b1, 1'b0);
    idle(2);
    tests_run++;
    if (host_req !== 1'b0 || end_cnt != e0) begin
      tests_failed++;
      $display("FAIL prefill_stop: got req=%b ends=%0d want 0/0", host_req, end_cnt - e0);
    end
    ctrl(1'b1, 1'b1, 1'b1);
    tests_run++;
    if (host_req !== 1'b0 || snd_if.snd_22k !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_wins: got req=%b 22k=%b want 0/0", host_req, snd_if.snd_22k);
    end
  endtask

  task automatic test_reset_midrun();
    int e0, s0;
    logic [9:0] outs;
    s0 = start_cnt;
    ctrl(1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'h0BAD_0001, 1'b0, 1'b0);
    drive(1'b1, 32'h0BAD_0002, 1'b0, 1'b0);
    idle(1);
    running = 1'b1;
    drive(1'b1, 32'h0BAD_0003, 1'b0, 1'b0);
    tests_run++;
    if (level !== 4'd3 || start_cnt != s0 + 1) begin
      tests_failed++;
      $display("FAIL midrun_setup: got lvl=%0d starts=%0d want 3/1", level, start_cnt - s0);
    end
    #3 rst_n = 1'b0;
    #1;
    outs = {snd_if.out_valid, snd_if.snd_start, snd_if.snd_end, snd_if.snd_22k,
            host_req, overflow, wr_ready, level[2:0]};
    tests_run++;
    if (outs !== 10'b0000_0010_00 || {level, underrun_cnt, snd_if.out_data} !== 44'h0) begin
      tests_failed++;
      $display("FAIL midrun_reset: got flags=%b lvl=%0d und=%0d data=%h want %b/0/0/0",
               outs, level, underrun_cnt, snd_if.out_data, 10'b0000_0010_00);
    end
    sb.delete();
    mlevel  = 0;
    running = 1'b0;
    e0 = end_cnt;
    idle(2);
    rst_n = 1'b1;
    idle(5);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    idle(2);
    tests_run++;
    if (end_cnt != e0 || level !== 4'd0 || host_req !== 1'b0 || underrun_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL post_reset: got ends=%0d lvl=%0d req=%b und=%0d want 0/0/0/0",
               end_cnt - e0, level, host_req, underrun_cnt);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    wr_valid        = 1'b0;
    wr_data         = '0;
    play_start      = 1'b0;
    play_stop       = 1'b0;
    rate_22k_in     = 1'b0;
    snd_if.req_tick = 1'b0;
    snd_if.req_mode = 1'b0;
    test_reset();
    test_prefill();
    test_underrun();
    test_overflow();
    test_drain();
    test_wrap_rate();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
